set_assoc_cache: RTL and testbench

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

---
 rtl/cache_pkg.sv | 14 +
 rtl/cache_way.sv | 54 +++++
 rtl/set_assoc_cache.sv | 148 ++++++++++++++
 tb/tb_set_assoc_cache.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: FSM state type and address-field width helpers shared by the cache and its way arrays.
package cache_pkg;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, UPDATE} cache_state_e;
  localparam int BYTE_BITS = 2;
  function automatic int word_bits(input int n_words);
    return $clog2(n_words);
  endfunction
  function automatic int set_bits(input int n_sets);
    return $clog2(n_sets);
  endfunction
  function automatic int tag_bits(input int n_sets, input int n_words);
    return 32 - BYTE_BITS - $clog2(n_words) - $clog2(n_sets);
  endfunction
endpackage

// File: rtl/cache_way.sv
// cache_way: tag, valid, dirty and data storage of one way across all sets.
module cache_way
  import cache_pkg::*;
#(
  parameter int N_SETS = 4,
  parameter int N_WORDS = 8,
  localparam int SI = set_bits(N_SETS),
  localparam int WI = word_bits(N_WORDS),
  localparam int TW = tag_bits(N_SETS, N_WORDS)
) (
  input  logic                     clk,
  input  logic                     rstn_i,
  input  logic [SI-1:0]            idx,
  output logic [TW-1:0]            tag_o,
  output logic                     valid_o,
  output logic                     dirty_o,
  output logic [N_WORDS-1:0][31:0] line_o,
  input  logic                     wr_en,
  input  logic [WI-1:0]            wr_word,
  input  logic [3:0]               wr_be,
  input  logic [31:0]              wr_data,
  input  logic                     fill_en,
  input  logic [TW-1:0]            fill_tag,
  input  logic [N_WORDS-1:0][31:0] fill_line
);
  logic [TW-1:0]            tags [N_SETS];
  logic [N_WORDS-1:0][31:0] data [N_SETS];
  logic [N_SETS-1:0]        valid, dirty;
  assign tag_o   = tags[idx];
  assign valid_o = valid[idx];
  assign dirty_o = dirty[idx];
  assign line_o  = data[idx];
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_en) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (wr_en) begin
      dirty[idx] <= 1'b1;
    end
  end
  // Payload arrays are left unreset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[idx] <= fill_tag;
      data[idx] <= fill_line;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) data[idx][wr_word][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end
endmodule

// File: rtl/set_assoc_cache.sv
// set_assoc_cache: write-back set-associative cache, zero-wait hits, word-serial writeback/refill.
// Define CACHE_STATS_EN to add hit_cnt_o / miss_cnt_o counters.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int N_SETS = 4,
  parameter int N_WAYS = 2,
  parameter int N_WORDS_PER_LINE = 8
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [3:0]  we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_valid_i
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);
  localparam int WI = word_bits(N_WORDS_PER_LINE);
  localparam int SI = set_bits(N_SETS);
  localparam int TW = tag_bits(N_SETS, N_WORDS_PER_LINE);
  localparam int WW = N_WAYS > 1 ? $clog2(N_WAYS) : 1;
  cache_state_e                      state;
  logic [WI-1:0]                     cnt;
  logic [TW-1:0]                     l_tag;
  logic [SI-1:0]                     l_set;
  logic [WW-1:0]                     victim, victim_c;
  logic [WW-1:0]                     rr [N_SETS];
  logic [N_WORDS_PER_LINE-1:0][31:0] line_buf;
  logic [TW-1:0]                     w_tag [N_WAYS];
  logic [N_WORDS_PER_LINE-1:0][31:0] w_line [N_WAYS];
  logic [N_WAYS-1:0]                 w_valid, w_dirty, hit_vec;
  logic [TW-1:0]                     req_tag;
  logic [SI-1:0]                     req_set, idx;
  logic [WI-1:0]                     req_word;
  logic [31:0]                       hit_word;
  logic                              idle, req, miss, wr_hit, last, unused_bits;
  assign req_tag     = addr_i[31 -: TW];
  assign req_set     = addr_i[WI+2 +: SI];
  assign req_word    = addr_i[2 +: WI];
  assign unused_bits = ^addr_i[1:0];
  assign idle        = state == IDLE;
  assign req         = read_i | write_i;
  // During a miss the arrays are indexed only by the latched set.
  assign idx         = idle ? req_set : l_set;
  assign valid_o     = idle && req && |hit_vec;
  assign miss        = idle && req && !(|hit_vec);
  assign wr_hit      = valid_o && write_i;
  assign data_o      = valid_o && !write_i ? hit_word : '0;
  assign last        = cnt == WI'(N_WORDS_PER_LINE - 1);
  assign mem_write_o = state == WRITEBACK;
  assign mem_read_o  = state == FILL;
  assign mem_addr_o  = mem_write_o ? {w_tag[victim], l_set, cnt, 2'b00} :
                       mem_read_o  ? {l_tag, l_set, cnt, 2'b00} : '0;
  assign mem_data_o  = mem_write_o ? w_line[victim][cnt] : '0;
  for (genvar w = 0; w < N_WAYS; w++) begin : g_way
    cache_way #(.N_SETS(N_SETS), .N_WORDS(N_WORDS_PER_LINE)) u_way (
      .clk      (clk),
      .rstn_i   (rstn_i),
      .idx      (idx),
      .tag_o    (w_tag[w]),
      .valid_o  (w_valid[w]),
      .dirty_o  (w_dirty[w]),
      .line_o   (w_line[w]),
      .wr_en    (wr_hit && hit_vec[w]),
      .wr_word  (req_word),
      .wr_be    (we_i),
      .wr_data  (data_i),
      .fill_en  (state == UPDATE && victim == WW'(w)),
      .fill_tag (l_tag),
      .fill_line(line_buf)
    );
    assign hit_vec[w] = w_valid[w] && w_tag[w] == req_tag;
  end
  always_comb begin
    hit_word = '0;
    for (int i = 0; i < N_WAYS; i++)
      hit_word = hit_word | (hit_vec[i] ? w_line[i][req_word] : '0);
  end
  // Lowest-index invalid way wins; otherwise the set's round-robin pointer.
  always_comb begin
    victim_c = rr[idx];
    for (int i = N_WAYS - 1; i >= 0; i--)
      if (!w_valid[i]) victim_c = WW'(i);
  end
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state  <= IDLE;
      cnt    <= '0;
      l_tag  <= '0;
      l_set  <= '0;
      victim <= '0;
      for (int i = 0; i < N_SETS; i++) rr[i] <= '0;
    end else begin
      case (state)
        IDLE: if (miss) begin
          l_tag  <= req_tag;
          l_set  <= req_set;
          victim <= victim_c;
          cnt    <= '0;
          state  <= w_valid[victim_c] && w_dirty[victim_c] ? WRITEBACK : FILL;
        end
        WRITEBACK: if (mem_valid_i) begin
          cnt <= cnt + 1'b1;
          if (last) state <= FILL;
        end
        FILL: if (mem_valid_i) begin
          cnt <= cnt + 1'b1;
          if (last) state <= UPDATE;
        end
        UPDATE: begin
          rr[l_set] <= rr[l_set] == WW'(N_WAYS - 1) ? '0 : rr[l_set] + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (state == FILL && mem_valid_i) line_buf[cnt] <= mem_data_i;
`ifdef CACHE_STATS_EN
  // The hit that completes a miss is not counted as a hit.
  logic post_fill;
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      post_fill  <= 1'b0;
    end else begin
      post_fill <= state == UPDATE;
      if (valid_o && !post_fill) hit_cnt_o <= hit_cnt_o + 1'b1;
      if (miss) miss_cnt_o <= miss_cnt_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_set_assoc_cache.sv
// tb_set_assoc_cache: directed scoreboard bench with a behavioural backing memory and CPU-view model.
module tb_set_assoc_cache;
  logic        clk = 1'b0, rstn_i = 1'b0, read_i = 1'b0, write_i = 1'b0, mem_valid_i = 1'b0;
  logic [3:0]  we_i = '0;
  logic [31:0] addr_i = '0, data_i = '0, mem_data_i = '0;
  logic [31:0] data_o, mem_addr_o, mem_data_o;
  logic        valid_o, mem_read_o, mem_write_o;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif
  typedef struct packed {logic w; logic [31:0] a; logic [31:0] d;} op_t;
  int          n_assert = 0, n_fail = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_m [logic [31:0]];
  logic [31:0] exp_q [$];
  op_t         exp_ops [$], got_ops [$];
  always #5 clk = ~clk;
  set_assoc_cache dut (
    .clk(clk), .rstn_i(rstn_i), .read_i(read_i), .write_i(write_i), .we_i(we_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .valid_o(valid_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_valid_i(mem_valid_i)
`ifdef CACHE_STATS_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );
  function automatic logic [31:0] init_w(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_w(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_m.exists(a) ? ref_m[a] : init_w(a);
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Backing memory answers one word per cycle.
  always @(negedge clk) begin
    if (mem_read_o || mem_write_o) check("strobe_excl", {31'b0, mem_read_o & mem_write_o}, 32'd0);
    mem_valid_i = 1'b0;
    if (mem_write_o) begin
      mem[mem_addr_o] = mem_data_o;
      got_ops.push_back(op_t'{1'b1, mem_addr_o, mem_data_o});
      mem_valid_i = 1'b1;
    end else if (mem_read_o) begin
      mem_data_i = mem_rd(mem_addr_o);
      got_ops.push_back(op_t'{1'b0, mem_addr_o, mem_data_i});
      mem_valid_i = 1'b1;
    end
  end
  task automatic exp_line(input logic w, input logic [31:0] base);
    for (int k = 0; k < 8; k++) exp_ops.push_back(op_t'{w, base + 32'(4*k), ref_rd(base + 32'(4*k))});
  endtask
  task automatic check_ops(input string tag);
    op_t g, e;
    check({tag, "_nops"}, 32'(got_ops.size()), 32'(exp_ops.size()));
    while (got_ops.size() > 0 && exp_ops.size() > 0) begin
      g = got_ops.pop_front();
      e = exp_ops.pop_front();
      check({tag, "_op_kind"}, {31'b0, g.w}, {31'b0, e.w});
      check({tag, "_op_addr"}, g.a, e.a);
      check({tag, "_op_data"}, g.d, e.d);
    end
    got_ops.delete();
    exp_ops.delete();
  endtask
  task automatic access(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] d, input int lat);
    logic [31:0] cur;
    int cyc;
    @(posedge clk); #1;
    read_i = rd; write_i = wr; addr_i = a; we_i = be; data_i = d;
    if (wr) begin
      cur = ref_rd(a);
      for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = d[8*b +: 8];
      ref_m[a] = cur;
      exp_q.push_back(32'd0);
    end else exp_q.push_back(ref_rd(a));
    cyc = 0;
    @(negedge clk);
    while (!valid_o && cyc < 200) begin
      if (cyc == 0) check({tag, "_data_wait"}, data_o, 32'd0);
      cyc++;
      @(negedge clk);
    end
    check({tag, "_lat"}, 32'(cyc), 32'(lat));
    check({tag, "_data"}, data_o, exp_q.pop_front());
    @(posedge clk); #1;
    read_i = 1'b0; write_i = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int cyc;
    logic seen;
    mem[32'h1004] = 32'h1122_3344;
    ref_m[32'h1004] = 32'h1122_3344;
    read_i = 1'b1; addr_i = 32'h1004;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_mrd", {31'b0, mem_read_o}, 32'd0);
    check("rst_mwr", {31'b0, mem_write_o}, 32'd0);
    check("rst_maddr", mem_addr_o, 32'd0);
    check("rst_mdata", mem_data_o, 32'd0);
    read_i = 1'b0;
    rstn_i = 1'b1;
    got_ops.delete();
    exp_line(1'b0, 32'h1000);
    access("rd_miss", 1, 0, 32'h1004, 4'h0, 0, 10);
    check_ops("rd_miss");
    access("rd_hit", 1, 0, 32'h1010, 4'h0, 0, 0);
    access("wr_hit", 0, 1, 32'h1004, 4'b0101, 32'hAABB_CCDD, 0);
    access("wr_hit_rd", 1, 0, 32'h1004, 4'h0, 0, 0);
    check("wr_hit_val", ref_rd(32'h1004), 32'h11BB_33DD);
    check_ops("hits");
    exp_line(1'b0, 32'h1080);
    access("way1_fill", 1, 0, 32'h1080, 4'h0, 0, 10);
    check_ops("way1_fill");
    exp_line(1'b1, 32'h1000);
    exp_line(1'b0, 32'h1100);
    access("dirty_miss", 1, 0, 32'h1100, 4'h0, 0, 18);
    check_ops("dirty_miss");
    access("second_tag_hit", 1, 0, 32'h1084, 4'h0, 0, 0);
    check_ops("second_tag_hit");
    exp_line(1'b0, 32'h1000);
    access("refetch_wb", 1, 0, 32'h1004, 4'h0, 0, 10);
    check_ops("refetch_wb");
    exp_line(1'b0, 32'h1180);
    @(posedge clk); #1;
    read_i = 1'b1; addr_i = 32'h1180;
    repeat (3) @(negedge clk);
    check("wd_valid", {31'b0, valid_o}, 32'd0);
    check("wd_data", data_o, 32'd0);
    @(posedge clk); #1;
    read_i = 1'b0;
    repeat (20) @(negedge clk);
    check_ops("withdrawn");
    access("wd_hit", 1, 0, 32'h1184, 4'h0, 0, 0);
    access("rw_both", 1, 1, 32'h1188, 4'b1010, 32'hCAFE_F00D, 0);
    access("rw_rd", 1, 0, 32'h1188, 4'h0, 0, 0);
    check_ops("rw");
    @(posedge clk); #1;
    read_i = 1'b1; addr_i = 32'h2040;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 50) begin
      @(negedge clk);
      seen = mem_read_o && mem_addr_o == 32'h204C;
      cyc++;
    end
    check("rf_word3_seen", {31'b0, seen}, 32'd1);
    #1 rstn_i = 1'b0; read_i = 1'b0;
    #1;
    check("rf_mrd", {31'b0, mem_read_o}, 32'd0);
    check("rf_mwr", {31'b0, mem_write_o}, 32'd0);
    check("rf_maddr", mem_addr_o, 32'd0);
    check("rf_valid", {31'b0, valid_o}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rstn_i = 1'b1;
    got_ops.delete();
    exp_ops.delete();
    ref_m = mem;
    exp_line(1'b0, 32'h2040);
    access("rf_again", 1, 0, 32'h2040, 4'h0, 0, 10);
    check_ops("rf_again");
    exp_line(1'b0, 32'h1180);
    access("rf_lost", 1, 0, 32'h1188, 4'h0, 0, 10);
    check_ops("rf_lost");
    exp_line(1'b0, 32'h2060);
    access("wr_miss", 0, 1, 32'h2064, 4'b1111, 32'h1234_5678, 10);
    access("wr_miss_rd", 1, 0, 32'h2064, 4'h0, 0, 0);
    check_ops("wr_miss");
`ifdef CACHE_STATS_EN
    begin
      logic [31:0] h0, m0;
      h0 = hit_cnt_o;
      m0 = miss_cnt_o;
      exp_line(1'b0, 32'h3000);
      access("st_miss", 1, 0, 32'h3000, 4'h0, 0, 10);
      access("st_hit1", 1, 0, 32'h3004, 4'h0, 0, 0);
      access("st_hit2", 1, 0, 32'h3008, 4'h0, 0, 0);
      access("st_hit3", 1, 0, 32'h300C, 4'h0, 0, 0);
      check_ops("stats");
      @(negedge clk);
      check("st_hits", hit_cnt_o - h0, 32'd3);
      check("st_miss_cnt", miss_cnt_o - m0, 32'd1);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
